muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide execution unit, sitting beside the ALU in the execute stage. It consumes the 5-bit ALU control codes 10010–11001 emitted by the ALU decoder for mul/mulh/mulhsu/mulhu/div/divu/rem/remu. It runs multi-cycle with a start/busy/done handshake so the pipeline control can stall on `busy`. Results are RISC-V-exact, including divide-by-zero and signed-overflow cases.

## Interface
- `DATA_WIDTH`, default 32: operand and result width. Only 32 is verified.
- `clk` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: request; sampled only when the unit is accepting (state IDLE or DONE).
- `alu_ctrl` input 5: operation code, sampled together with `start`.
- `src1_value` input 32: rs1 value, sampled with `start`.
- `src2_value` input 32: rs2 value, sampled with `start`.
- `kill` input 1: synchronous abort, for a pipeline flush.
- `busy` output 1: high in states MUL and DIV.
- `done` output 1: one-cycle pulse, high in state DONE.
- `result` output 32: the final value; valid while `done` is high and held until the next accepted start.

## Operation
- Codes:
  - 10010 mul: low 32 bits of the product.
  - 10011 mulh: high 32 bits, signed×signed.
  - 10100 mulhsu: high 32 bits, signed×unsigned.
  - 10101 mulhu: high 32 bits, unsigned×unsigned.
  - 10110 div, 10111 divu: quotient, signed / unsigned.
  - 11000 rem, 11001 remu: remainder, signed / unsigned.
- Acceptance: `start` with any other code is ignored; state is unchanged and no `done` is produced.
- FSM states are IDLE, MUL, DIV, DONE.
  - IDLE/DONE + accepted mul* → MUL.
  - IDLE/DONE + accepted div*/rem* with src2≠0 → DIV.
  - IDLE/DONE + accepted div*/rem* with src2=0 → DONE.
  - MUL → DONE after 1 cycle.
  - DIV → DONE after its 32nd iteration (5-bit counter counts 31 down to 0).
  - DONE → IDLE when no start is accepted.
- MUL: operands are sign- or zero-extended to 33 bits per op, giving a 66-bit product register. Take [31:0] for mul, [63:32] otherwise.
- DIV: restoring algorithm on magnitudes (absolute values for signed ops), one quotient bit per cycle, 33-bit partial remainder.
  - Quotient sign = src1[31] XOR src2[31] (signed ops only).
  - Remainder sign = src1[31] (signed ops only).
  - Signs are applied on entry to DONE.
- Divide by zero: quotient = 0xFFFFFFFF; remainder = src1 (signed and unsigned alike).
- Overflow (0x80000000 / 0xFFFFFFFF, signed): quotient 0x80000000, remainder 0. This falls out of the magnitude algorithm with no special case.
- `kill`: forces IDLE next cycle from any state, and overrides `start` in the same cycle. `done` is suppressed and `result` is unchanged.
- A `start` while busy is ignored and is not queued.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0, internal registers 0.
- Reset mid-operation aborts immediately and asynchronously.
- Latency, counted from the edge that samples `start` to the cycle in which `done`=1:
  - mul*: 2 cycles.
  - div*/rem* with nonzero divisor: 33 cycles.
  - Divide by zero: 1 cycle.
- `busy` rises in the cycle after acceptance and falls in the cycle `done` rises.
- Back-to-back: a `start` in the DONE cycle is accepted. The next operation begins with no idle gap, and `result` holds until that operation's DONE.
- `done` is never high for two consecutive cycles for the same operation.

## Structure
- Package `muldiv_pkg` holds:
  - localparams for the eight alu_ctrl codes (shared with the ALU decoder);
  - the state enum `muldiv_state_t`;
  - the `DIV_ITERS` = 32 constant.
- Sub-module `div_step` is combinational: one restoring iteration. Inputs are the partial remainder, the dividend shift bit and the divisor. Outputs are the next partial remainder and the quotient bit.
- All arithmetic uses explicit 33/66-bit widths and no implicit truncation.

## Test plan
- mul 7×(−3): `result` 0xFFFFFFEB with `done` 2 cycles after start. mulh 0x80000000×0x80000000 → 0x40000000; mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; mulhsu −1×0xFFFFFFFF → 0xFFFFFFFF.
- div −7/2 → 0xFFFFFFFD; rem −7/2 → 0xFFFFFFFF; divu 100/7 → 14; remu 100/7 → 2. `done` exactly 33 cycles after start and `busy` high for 32 cycles.
- Divide by zero: div 5/0 → 0xFFFFFFFF; remu 5/0 → 5; `done` 1 cycle after start and `busy` never high.
- Overflow: div 0x80000000/−1 → 0x80000000; rem → 0.
- Handshake: `start` pulsed mid-DIV is ignored; `start` in the DONE cycle is accepted and the second result arrives with correct latency. `start` with alu_ctrl 00000 gives no `busy` and no `done`.
- Abort: `kill` at cycle 10 of a div returns to IDLE with no `done` and `result` unchanged. `reset` asserted mid-MUL drives all outputs to 0 asynchronously.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: ALU control codes,
// FSM state type and the restoring-divide iteration count.
package muldiv_pkg;

  localparam logic [4:0] ALU_MUL    = 5'b10010;
  localparam logic [4:0] ALU_MULH   = 5'b10011;
  localparam logic [4:0] ALU_MULHSU = 5'b10100;
  localparam logic [4:0] ALU_MULHU  = 5'b10101;
  localparam logic [4:0] ALU_DIV    = 5'b10110;
  localparam logic [4:0] ALU_DIVU   = 5'b10111;
  localparam logic [4:0] ALU_REM    = 5'b11000;
  localparam logic [4:0] ALU_REMU   = 5'b11001;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_t;

  function automatic logic is_mul_op(input logic [4:0] code);
    return code inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic is_div_op(input logic [4:0] code);
    return code inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_signed_div(input logic [4:0] code);
    return code inside {ALU_DIV, ALU_REM};
  endfunction

  function automatic logic is_quot_op(input logic [4:0] code);
    return code inside {ALU_DIV, ALU_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic         shift_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // The remainder is always below the divisor, so the shifted value fits in
  // W+1 bits and the top bit of the difference is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, shift_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[W+1];
    rem_out = q_bit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Multiply takes one registered cycle; divide is restoring, one bit per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] src1_value,
  input  logic [DATA_WIDTH-1:0] src2_value,
  input  logic                  kill,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DIV_ITERS);

  muldiv_state_t  state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   result_q, result_d;
  logic [4:0]     op_q, op_d;
  logic [2*W+1:0] prod_q, prod_d;
  logic [W:0]     rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;

  logic           op_is_mul, op_is_div, op_sdiv, accept;
  logic           a_signed, b_signed;
  logic [W:0]     a_ext, b_ext;
  logic [2*W+1:0] prod_full;
  logic [W-1:0]   mag1, mag2;
  logic [W:0]     step_rem;
  logic           step_q;
  logic [W-1:0]   q_final, r_final, div_final;
  logic           unused_prod_hi;

  assign op_is_mul = is_mul_op(alu_ctrl);
  assign op_is_div = is_div_op(alu_ctrl);
  assign op_sdiv   = is_signed_div(alu_ctrl);
  assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE)
                     && (op_is_mul || op_is_div);

  // Sign/zero extension to W+1 bits lets one signed multiplier serve all four ops.
  assign a_signed  = alu_ctrl inside {ALU_MUL, ALU_MULH, ALU_MULHSU};
  assign b_signed  = alu_ctrl inside {ALU_MUL, ALU_MULH};
  assign a_ext     = {a_signed & src1_value[W-1], src1_value};
  assign b_ext     = {b_signed & src2_value[W-1], src2_value};
  assign prod_full = $signed({{(W+1){a_ext[W]}}, a_ext})
                   * $signed({{(W+1){b_ext[W]}}, b_ext});

  assign mag1 = (op_sdiv && src1_value[W-1]) ? -src1_value : src1_value;
  assign mag2 = (op_sdiv && src2_value[W-1]) ? -src2_value : src2_value;

  div_step #(.W(W)) u_div_step (
    .rem_in   (rem_q),
    .shift_in (quo_q[W-1]),
    .divisor  (dvsr_q),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  assign q_final   = {quo_q[W-2:0], step_q};
  assign r_final   = step_rem[W-1:0];
  assign div_final = is_quot_op(op_q) ? (neg_quo_q ? -q_final : q_final)
                                      : (neg_rem_q ? -r_final : r_final);

  assign unused_prod_hi = ^prod_q[2*W+1:2*W];

  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    op_d      = op_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (accept) begin
            op_d = alu_ctrl;
            if (op_is_mul) begin
              prod_d  = prod_full;
              state_d = ST_MUL;
            end else if (src2_value == '0) begin
              result_d = is_quot_op(alu_ctrl) ? '1 : src1_value;
              state_d  = ST_DONE;
            end else begin
              rem_d     = '0;
              quo_d     = mag1;
              dvsr_d    = mag2;
              cnt_d     = CNT_W'(DIV_ITERS - 1);
              neg_quo_d = op_sdiv & (src1_value[W-1] ^ src2_value[W-1]);
              neg_rem_d = op_sdiv & src1_value[W-1];
              state_d   = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          result_d = (op_q == ALU_MUL) ? prod_q[W-1:0] : prod_q[2*W-1:W];
          state_d  = ST_DONE;
        end
        ST_DIV: begin
          rem_d = step_rem;
          quo_d = q_final;
          if (cnt_q == '0) begin
            result_d = div_final;
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      endcase
    end

    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      op_q      <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      op_q      <= op_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
